// File: rtl/pwm_ramp_seq_if.sv
// Result port of the PWM-ramp scan sequencer: one averaged sample per channel on valid/ready.
interface pwm_ramp_seq_if #(
   parameter int unsigned NBITS = 8,
   parameter int unsigned NCH   = 4
);
   localparam int unsigned CW = $clog2(NCH);

   logic             valid;
   logic             ready;
   logic [NBITS-1:0] data;
   logic [CW-1:0]    ch;
   logic             timeout;

   modport master (output valid, data, ch, timeout, input ready);
   modport slave  (input valid, data, ch, timeout, output ready);
endinterface

// File: rtl/pwm_ramp_seq.sv
// Scan sequencer for the PWM-ramp ADC: steps the analog mux over enabled channels,
// gates the ramp, averages 2^k samples per channel and presents one result per channel.
module pwm_ramp_seq #(
   parameter int unsigned NBITS     = 8,
   parameter int unsigned NCH       = 4,
   parameter int unsigned TIMEOUT_W = 20
) (
   input  logic                    clk_i,
   input  logic                    rst_ni,
   input  logic                    start_i,
   input  logic                    continuous_i,
   input  logic [NCH-1:0]          ch_mask_i,
   input  logic [1:0]              avg_log2_i,
   input  logic [7:0]              settle_i,
   input  logic [TIMEOUT_W-1:0]    timeout_i,
   output logic                    ramp_en_o,
   output logic                    ramp_clr_o,
   output logic [$clog2(NCH)-1:0]  ch_sel_o,
   input  logic [NBITS-1:0]        adc_value_i,
   input  logic                    adc_valid_i,
   pwm_ramp_seq_if.master          res,
   output logic                    busy_o,
   output logic                    done_o
);
   localparam int unsigned CW    = $clog2(NCH);
   localparam int unsigned ACC_W = NBITS + 3;
   localparam int unsigned CNT_W = 4;

   localparam logic [1:0] IDLE    = 2'd0;
   localparam logic [1:0] SETTLE  = 2'd1;
   localparam logic [1:0] CONVERT = 2'd2;
   localparam logic [1:0] RESULT  = 2'd3;

   logic [1:0]           state_q, state_n;
   logic [NCH-1:0]       mask_q, mask_n;
   logic [1:0]           avg_q, avg_n;
   logic [7:0]           settle_q, settle_n;
   logic [TIMEOUT_W-1:0] timeout_q, timeout_n;
   logic                 cont_q, cont_n;
   logic [7:0]           settle_cnt_q, settle_cnt_n;
   logic [TIMEOUT_W-1:0] tcnt_q, tcnt_n;
   logic [CNT_W-1:0]     cnt_q, cnt_n;
   logic [ACC_W-1:0]     acc_q, acc_n;
   logic                 tflag_q, tflag_n;
   logic                 ramp_en_q, ramp_en_n;
   logic                 ramp_clr_q, ramp_clr_n;
   logic [CW-1:0]        ch_sel_q, ch_sel_n;
   logic                 res_valid_q, res_valid_n;
   logic [NBITS-1:0]     res_data_q, res_data_n;
   logic [CW-1:0]        res_ch_q, res_ch_n;
   logic                 res_to_q, res_to_n;
   logic                 busy_q, busy_n;
   logic                 done_q, done_n;

   logic [CW-1:0]        start_ch, wrap_ch, next_ch;
   logic                 next_ok;
   logic                 take, to_hit, tflag_sum;
   logic [ACC_W-1:0]     sample, acc_sum;

   // Channel search: descending loops leave the lowest qualifying index.
   always_comb begin
      start_ch = '0;
      wrap_ch  = '0;
      next_ch  = '0;
      next_ok  = 1'b0;
      for (int i = NCH - 1; i >= 0; i--) begin
         if (ch_mask_i[i]) start_ch = CW'(i);
         if (mask_q[i])    wrap_ch  = CW'(i);
         if (mask_q[i] && (i > int'(ch_sel_q))) begin
            next_ch = CW'(i);
            next_ok = 1'b1;
         end
      end
   end

   always_comb begin
      state_n      = state_q;
      mask_n       = mask_q;
      avg_n        = avg_q;
      settle_n     = settle_q;
      timeout_n    = timeout_q;
      cont_n       = cont_q;
      settle_cnt_n = settle_cnt_q;
      tcnt_n       = tcnt_q;
      cnt_n        = cnt_q;
      acc_n        = acc_q;
      tflag_n      = tflag_q;
      ramp_en_n    = ramp_en_q;
      ramp_clr_n   = 1'b0;
      ch_sel_n     = ch_sel_q;
      res_valid_n  = res_valid_q;
      res_data_n   = res_data_q;
      res_ch_n     = res_ch_q;
      res_to_n     = res_to_q;
      done_n       = 1'b0;
      take         = 1'b0;
      to_hit       = 1'b0;
      sample       = '0;
      acc_sum      = acc_q;
      tflag_sum    = tflag_q;

      case (state_q)
         IDLE: begin
            if (start_i && (ch_mask_i != '0)) begin
               mask_n       = ch_mask_i;
               avg_n        = avg_log2_i;
               settle_n     = settle_i;
               timeout_n    = timeout_i;
               cont_n       = continuous_i;
               ch_sel_n     = start_ch;
               settle_cnt_n = '0;
               state_n      = SETTLE;
            end
         end
         SETTLE: begin
            if (({1'b0, settle_cnt_q} + 9'd1) >= {1'b0, settle_q}) begin
               settle_cnt_n = '0;
               tcnt_n       = '0;
               ramp_en_n    = 1'b1;
               state_n      = CONVERT;
            end else begin
               settle_cnt_n = settle_cnt_q + 8'd1;
            end
         end
         CONVERT: begin
            if (ramp_clr_q) begin
               // Ramp is restarting after an aborted sample; resume on the next cycle.
               ramp_en_n = 1'b1;
            end else begin
               if (adc_valid_i) begin
                  take   = 1'b1;
                  sample = ACC_W'(adc_value_i);
               end else if ((timeout_q != '0) && ((tcnt_q + TIMEOUT_W'(1)) == timeout_q)) begin
                  take       = 1'b1;
                  to_hit     = 1'b1;
                  sample     = ACC_W'({NBITS{1'b1}});
                  ramp_clr_n = 1'b1;
                  ramp_en_n  = 1'b0;
               end else begin
                  tcnt_n = tcnt_q + TIMEOUT_W'(1);
               end
               if (take) begin
                  acc_sum   = acc_q + sample;
                  tflag_sum = tflag_q | to_hit;
                  acc_n     = acc_sum;
                  tflag_n   = tflag_sum;
                  cnt_n     = cnt_q + CNT_W'(1);
                  tcnt_n    = '0;
                  if ((cnt_q + CNT_W'(1)) == (CNT_W'(1) << avg_q)) begin
                     ramp_en_n   = 1'b0;
                     res_valid_n = 1'b1;
                     res_data_n  = NBITS'(acc_sum >> avg_q);
                     res_ch_n    = ch_sel_q;
                     res_to_n    = tflag_sum;
                     state_n     = RESULT;
                  end
               end
            end
         end
         RESULT: begin
            if (res.ready) begin
               res_valid_n  = 1'b0;
               acc_n        = '0;
               cnt_n        = '0;
               tflag_n      = 1'b0;
               settle_cnt_n = '0;
               if (next_ok) begin
                  ch_sel_n = next_ch;
                  state_n  = SETTLE;
               end else begin
                  done_n = 1'b1;
                  if (cont_q) begin
                     ch_sel_n = wrap_ch;
                     state_n  = SETTLE;
                  end else begin
                     state_n = IDLE;
                  end
               end
            end
         end
         default: state_n = IDLE;
      endcase

      busy_n = (state_n != IDLE);
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_q      <= IDLE;
         mask_q       <= '0;
         avg_q        <= '0;
         settle_q     <= '0;
         timeout_q    <= '0;
         cont_q       <= 1'b0;
         settle_cnt_q <= '0;
         tcnt_q       <= '0;
         cnt_q        <= '0;
         acc_q        <= '0;
         tflag_q      <= 1'b0;
         ramp_en_q    <= 1'b0;
         ramp_clr_q   <= 1'b0;
         ch_sel_q     <= '0;
         res_valid_q  <= 1'b0;
         res_data_q   <= '0;
         res_ch_q     <= '0;
         res_to_q     <= 1'b0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
      end else begin
         state_q      <= state_n;
         mask_q       <= mask_n;
         avg_q        <= avg_n;
         settle_q     <= settle_n;
         timeout_q    <= timeout_n;
         cont_q       <= cont_n;
         settle_cnt_q <= settle_cnt_n;
         tcnt_q       <= tcnt_n;
         cnt_q        <= cnt_n;
         acc_q        <= acc_n;
         tflag_q      <= tflag_n;
         ramp_en_q    <= ramp_en_n;
         ramp_clr_q   <= ramp_clr_n;
         ch_sel_q     <= ch_sel_n;
         res_valid_q  <= res_valid_n;
         res_data_q   <= res_data_n;
         res_ch_q     <= res_ch_n;
         res_to_q     <= res_to_n;
         busy_q       <= busy_n;
         done_q       <= done_n;
      end
   end

   assign ramp_en_o   = ramp_en_q;
   assign ramp_clr_o  = ramp_clr_q;
   assign ch_sel_o    = ch_sel_q;
   assign busy_o      = busy_q;
   assign done_o      = done_q;
   assign res.valid   = res_valid_q;
   assign res.data    = res_data_q;
   assign res.ch      = res_ch_q;
   assign res.timeout = res_to_q;
endmodule

// File: tb/tb_pwm_ramp_seq.sv
// Directed bench for pwm_ramp_seq: scan order, averaging, timeout, back-pressure, continuous mode, reset.
module tb_pwm_ramp_seq;
   logic        clk;
   logic        rst_n;
   logic        start;
   logic        cont;
   logic [3:0]  mask;
   logic [1:0]  avg;
   logic [7:0]  settle;
   logic [19:0] tmo;
   logic        ramp_en;
   logic        ramp_clr;
   logic [1:0]  ch_sel;
   logic [7:0]  adc_value;
   logic        adc_valid;
   logic        busy;
   logic        done;

   int n_cmp = 0;
   int n_err = 0;

   pwm_ramp_seq_if #(.NBITS(8), .NCH(4)) res_if ();

   pwm_ramp_seq #(.NBITS(8), .NCH(4), .TIMEOUT_W(20)) dut (
      .clk_i        (clk),
      .rst_ni       (rst_n),
      .start_i      (start),
      .continuous_i (cont),
      .ch_mask_i    (mask),
      .avg_log2_i   (avg),
      .settle_i     (settle),
      .timeout_i    (tmo),
      .ramp_en_o    (ramp_en),
      .ramp_clr_o   (ramp_clr),
      .ch_sel_o     (ch_sel),
      .adc_value_i  (adc_value),
      .adc_valid_i  (adc_valid),
      .res          (res_if),
      .busy_o       (busy),
      .done_o       (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
      end
   endtask

   // Present one ADC sample after 'gap' idle cycles; returns just after it was sampled.
   task automatic give(input logic [7:0] v, input int gap);
      repeat (gap) tick();
      adc_value = v;
      adc_valid = 1'b1;
      tick();
      adc_valid = 1'b0;
   endtask

   task automatic accept();
      res_if.ready = 1'b1;
      tick();
      res_if.ready = 1'b0;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   initial begin
      rst_n = 1'b0; start = 1'b0; cont = 1'b0; mask = '0; avg = '0; settle = '0; tmo = '0;
      adc_value = '0; adc_valid = 1'b0; res_if.ready = 1'b0;
      repeat (3) tick();
      chk("rst_busy",    32'(busy), 0);
      chk("rst_ramp_en", 32'(ramp_en), 0);
      chk("rst_valid",   32'(res_if.valid), 0);
      chk("rst_ch_sel",  32'(ch_sel), 0);
      chk("rst_done",    32'(done), 0);
      rst_n = 1'b1;
      tick();

      // Two-channel scan, settle=2, one sample each, with 20 cycles of back-pressure
      mask = 4'b0101; avg = 2'd0; settle = 8'd2; tmo = '0;
      pulse_start();
      chk("a_sel0",   32'(ch_sel), 0);
      chk("a_busy",   32'(busy), 1);
      chk("a_en_c1",  32'(ramp_en), 0);
      tick();
      chk("a_en_c2",  32'(ramp_en), 0);
      tick();
      chk("a_en_c3",  32'(ramp_en), 1);
      give(8'h40, 99);
      chk("a_valid0", 32'(res_if.valid), 1);
      chk("a_data0",  32'(res_if.data), 32'h40);
      chk("a_ch0",    32'(res_if.ch), 0);
      chk("a_en_res", 32'(ramp_en), 0);
      for (int k = 0; k < 20; k++) begin
         tick();
         chk("hold_valid", 32'(res_if.valid), 1);
         chk("hold_data",  32'({res_if.data, 2'(res_if.ch), res_if.timeout}), 32'({8'h40, 2'd0, 1'b0}));
         chk("hold_en_sel", 32'({ramp_en, ch_sel}), 32'({1'b0, 2'd0}));
      end
      accept();
      chk("a_sel2",     32'(ch_sel), 2);
      chk("a_valid_lo", 32'(res_if.valid), 0);
      chk("a_done_mid", 32'(done), 0);
      tick();
      chk("a_en2_c2",   32'(ramp_en), 0);
      tick();
      chk("a_en2_c3",   32'(ramp_en), 1);
      give(8'h40, 10);
      chk("a_ch2",      32'(res_if.ch), 2);
      chk("a_data2",    32'(res_if.data), 32'h40);
      accept();
      chk("a_done",     32'(done), 1);
      chk("a_idle",     32'(busy), 0);
      tick();
      chk("a_done_off", 32'(done), 0);

      // Averaging 4 samples on ch1: (10+11+12+13)>>2 = 11
      mask = 4'b0010; avg = 2'd2; settle = 8'd0;
      pulse_start();
      chk("b_sel1", 32'(ch_sel), 1);
      tick();
      chk("b_en", 32'(ramp_en), 1);
      give(8'd10, 3);
      give(8'd11, 3);
      chk("b_mid", 32'({ramp_en, res_if.valid}), 32'({1'b1, 1'b0}));
      give(8'd12, 3);
      give(8'd13, 3);
      chk("b_valid", 32'(res_if.valid), 1);
      chk("b_data",  32'(res_if.data), 11);
      chk("b_to",    32'(res_if.timeout), 0);
      chk("b_ch",    32'(res_if.ch), 1);
      accept();
      chk("b_done",  32'(done), 1);
      tick();

      // Timeout of 50 with no conversion: ramp_clr 50 cycles into CONVERT, all-ones result
      mask = 4'b0001; avg = 2'd0; settle = 8'd0; tmo = 20'd50;
      pulse_start();
      tick();
      repeat (49) tick();
      chk("c_clr_early", 32'({ramp_clr, res_if.valid}), 0);
      tick();
      chk("c_clr",   32'(ramp_clr), 1);
      chk("c_en",    32'(ramp_en), 0);
      chk("c_valid", 32'(res_if.valid), 1);
      chk("c_data",  32'(res_if.data), 32'hFF);
      chk("c_to",    32'(res_if.timeout), 1);
      tick();
      chk("c_clr_pulse", 32'(ramp_clr), 0);
      accept();
      tick();

      // Valid in the very cycle the timeout would expire: sample wins
      tmo = 20'd5;
      pulse_start();
      tick();
      give(8'h22, 4);
      chk("d_data", 32'(res_if.data), 32'h22);
      chk("d_to",   32'(res_if.timeout), 0);
      chk("d_clr",  32'(ramp_clr), 0);
      accept();
      tick();

      // Continuous scan over ch0/ch3, late config changes and start while busy ignored
      mask = 4'b1001; avg = 2'd0; settle = 8'd0; tmo = '0; cont = 1'b1;
      pulse_start();
      chk("e_sel0", 32'(ch_sel), 0);
      tick();
      give(8'h11, 2);
      chk("e_res0", 32'({res_if.ch, res_if.data}), 32'({2'd0, 8'h11}));
      accept();
      cont = 1'b0;
      chk("e_sel3", 32'(ch_sel), 3);
      tick();
      give(8'h33, 1);
      chk("e_res3", 32'({res_if.ch, res_if.data}), 32'({2'd3, 8'h33}));
      accept();
      chk("e_done", 32'(done), 1);
      chk("e_wrap", 32'(ch_sel), 0);
      chk("e_busy", 32'(busy), 1);
      tick();
      mask = 4'b0010;
      pulse_start();
      mask = 4'b1001;
      give(8'h55, 1);
      chk("e_res0b", 32'({res_if.ch, res_if.data}), 32'({2'd0, 8'h55}));
      accept();
      chk("e_order", 32'(ch_sel), 3);
      tick();
      tick();
      chk("e_conv", 32'(ramp_en), 1);
      rst_n = 1'b0;
      tick();
      chk("e_rst_busy", 32'(busy), 0);
      chk("e_rst_out",  32'({ramp_en, ramp_clr, ch_sel, res_if.valid, done}), 0);
      chk("e_rst_res",  32'({res_if.data, res_if.ch, res_if.timeout}), 0);
      rst_n = 1'b1;
      cont = 1'b0;
      tick();

      // Start with an empty mask is ignored
      mask = 4'b0000;
      pulse_start();
      chk("f_busy", 32'(busy), 0);
      tick();
      chk("f_done", 32'({busy, done}), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
